// File: rtl/instruction_cs.sv
// rtl/instruction_cs.sv - c.sw store sequencer: decode, address generation and RAM write handshake
module instruction_cs #(
    parameter int ADDR_W      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iSTART,
    input  logic [15:0]       iIR,
    input  logic [31:0]       iRS1,
    input  logic [31:0]       iRS2,
    output logic [4:0]        oRS1,
    output logic [4:0]        oRS2,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic              oRAM_WR,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    output logic [31:0]       oRAM_DATA,
    input  logic              iRAM_ACK,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oERR
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;

    logic                legal;
    logic [6:0]          imm;
    logic [31:0]         ea;
    logic                unused_ea;

    assign oRS1  = 5'h8 + {2'b00, iIR[9:7]};
    assign oRS2  = 5'h8 + {2'b00, iIR[4:2]};

    assign legal = (iIR[1:0] == 2'b00) && (iIR[15:13] == 3'b110);
    assign imm   = {iIR[5], iIR[12:10], iIR[6], 2'b00};
    assign ea    = iRS1 + {25'd0, imm};
    // Byte address bits above the RAM word range are dropped, so addresses wrap.
    assign unused_ea = ^ea[31:ADDR_W+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    if (legal && (ea[1:0] == 2'b00)) begin
                        addr_d  = ea[ADDR_W+1:2];
                        data_d  = iRS2;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_REQ: begin
                // An ACK on the final counted cycle still wins over the timeout.
                if (iRAM_ACK) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign oRAM_CE   = (state_q == S_REQ);
    assign oRAM_WR   = (state_q == S_REQ);
    assign oRAM_RD   = 1'b0;
    assign oRAM_ADDR = addr_q;
    assign oRAM_DATA = data_q;
    assign oBUSY     = (state_q != S_IDLE);
    assign oDONE     = (state_q == S_DONE);
    assign oERR      = (state_q == S_ERR);

endmodule

// File: doc/instruction_cs.md
INSTRUCTION_CS -- requirements
Module: instruction_cs

Interface
REQ-001 Parameter ADDR_W, default 8, width of the RAM word address.
REQ-002 Parameter ACK_TIMEOUT, default 15, number of REQ cycles without iRAM_ACK before the store aborts.
REQ-003 iCLK  input  1  single clock; all state updates on its rising edge.
REQ-004 iRST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 iSTART  input  1  one-cycle issue strobe for the instruction on iIR.
REQ-006 iIR  input  16  compressed instruction; CS format, c.sw expected.
REQ-007 iRS1  input  32  value of base register rs1'.
REQ-008 iRS2  input  32  value of store-data register rs2'.
REQ-009 oRS1 and oRS2  output  5 each  register indices: 5'h8 + iIR[9:7] and 5'h8 + iIR[4:2]; combinational.
REQ-010 oRAM_CE, oRAM_RD, oRAM_WR  output  1 each  RAM strobes.
REQ-011 oRAM_ADDR  output  ADDR_W  RAM word address.
REQ-012 oRAM_DATA  output  32  RAM write data.
REQ-013 iRAM_ACK  input  1  RAM write-accept, sampled only in REQ.
REQ-014 oBUSY  output  1  high in every state other than IDLE.
REQ-015 oDONE  output  1  one-cycle pulse on successful store.
REQ-016 oERR  output  1  one-cycle pulse on illegal, misaligned or timed-out store.

Function
REQ-017 Decode: OP = iIR[1:0], FUNC3 = iIR[15:13]; legal only when OP = 2'b00 and FUNC3 = 3'b110 (c.sw).
REQ-018 Offset IMM = {iIR[5], iIR[12:10], iIR[6], 2'b00}, zero-extended, range 0..124.
REQ-019 Byte address EA = iRS1 + IMM, computed mod 2^32; word address = EA[ADDR_W+1:2]; higher bits are discarded, so addresses wrap.
REQ-020 FSM states: IDLE, REQ, DONE, ERR.
REQ-021 IDLE + iSTART + legal + EA[1:0] = 0: capture word address into oRAM_ADDR and iRS2 into oRAM_DATA; go to REQ next cycle.
REQ-022 IDLE + iSTART + (illegal or EA[1:0] != 0): go to ERR; no RAM strobe is asserted.
REQ-023 REQ: oRAM_CE = 1 and oRAM_WR = 1; oRAM_ADDR and oRAM_DATA are held stable whatever iRS1, iRS2 or iIR do.
REQ-024 REQ + iRAM_ACK = 1: go to DONE; minimum issue-to-oDONE latency is 2 cycles (iSTART at cycle N, ACK at N+1, oDONE at N+2).
REQ-025 REQ uses a wait counter cleared on entry; when ACK_TIMEOUT cycles pass without ACK, go to ERR.
REQ-026 An ACK in the same cycle the counter expires counts as success (go to DONE).
REQ-027 DONE: oDONE = 1 for one cycle, then IDLE. ERR: oERR = 1 for one cycle, then IDLE.
REQ-028 iSTART outside IDLE is ignored and not queued; the next store can issue in the cycle after DONE or ERR.
REQ-029 oRAM_RD is always 0; oRAM_CE and oRAM_WR are 0 in every state except REQ.

Reset
REQ-030 iRST_N low immediately forces IDLE and clears the counter, oRAM_ADDR, oRAM_DATA, all strobes, oBUSY, oDONE and oERR, without waiting for iCLK.
REQ-031 Reset during REQ drops oRAM_WR in the same cycle; the aborted store produces neither oDONE nor oERR.
REQ-032 After iRST_N rises, the first iSTART is accepted on the next iCLK edge.

Verification
REQ-033 iIR=0xC044, iRS1=0x100, iRS2=0xDEADBEEF, ACK one cycle after REQ entry -> oRS1=8, oRS2=9, oRAM_ADDR=0x41, oRAM_DATA=0xDEADBEEF, oDONE at N+2.
REQ-034 iIR=0xDC60, iRS1=0x3FC -> EA=0x478, oRAM_ADDR=0x1E (wrapped); iRS2 changed during REQ does not change oRAM_DATA.
REQ-035 iIR=0xC044, iRS1=0x102 -> oERR pulse at N+1; oRAM_CE stays 0 throughout.
REQ-036 iIR=0x4044 (c.lw) -> oERR pulse; no RAM write.
REQ-037 iRAM_ACK held 0 -> oRAM_WR high for exactly 15 cycles, then an oERR pulse; a second iSTART during REQ is ignored.
REQ-038 iRST_N pulsed low mid-REQ -> all outputs 0 asynchronously, no oDONE; a store issued after release completes normally.
